// File: rtl/blink_pkg.sv
// Shared encodings for the multi-channel blink generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package blink_pkg;

  // Width of a single channel's mode field in the packed mode bus.
  localparam int MODE_W = 2;

  // Channel operating modes.
  localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_FREE  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BURST = 2'd2;
  localparam logic [MODE_W-1:0] MODE_SOLID = 2'd3;

  // Per-channel FSM state encoding.
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_HIGH = 2'd1;
  localparam logic [ST_W-1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/blink_channel.sv
// One blink channel: phase FSM, half-period counter, burst counter, output regs.
// Latency: outputs registered; a change of enable/mode/start shows one cycle later.
// Backpressure: none; free-running generator with no flow control.
module blink_channel
  import blink_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [MODE_W-1:0]  mode,
  input  logic [CNT_W-1:0]   half_period,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               start,
  output logic               blink_out,
  output logic               tick,
  output logic               busy
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  logic [ST_W-1:0]    state;
  logic [ST_W-1:0]    state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [BURST_W-1:0] remain;
  logic [BURST_W-1:0] remain_nxt;
  logic [MODE_W-1:0]  mode_q;
  logic               abort;
  logic               terminal;
  logic               phase_end;
  logic               blink_nxt;
  logic               tick_nxt;
  logic               busy_nxt;

  // A disable or any change of mode drops the channel to idle and discards
  // a pending burst; the new mode is obeyed starting the following cycle.
  assign abort = !enable || (mode != mode_q);

  // ">=" so that lowering the half-period mid-phase ends the phase at once
  // instead of letting the counter wrap all the way round.
  assign terminal = (cnt >= half_period);

  // State, counter, burst-remaining and previous-mode registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      remain <= '0;
      mode_q <= MODE_OFF;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      remain <= remain_nxt;
      mode_q <= mode;
    end
  end

  // Next-state: phase sequencing, counter and burst bookkeeping
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    remain_nxt = remain;
    phase_end  = 1'b0;
    if (abort) begin
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      remain_nxt = '0;
    end else begin
      case (mode)
        MODE_FREE: begin
          case (state)
            ST_IDLE: begin
              state_nxt = ST_HIGH;
              cnt_nxt   = '0;
            end
            ST_HIGH, ST_LOW: begin
              if (terminal) begin
                phase_end = 1'b1;
                cnt_nxt   = '0;
                state_nxt = (state == ST_HIGH) ? ST_LOW : ST_HIGH;
              end else begin
                cnt_nxt = cnt + CNT_ONE;
              end
            end
            default: begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end
          endcase
          remain_nxt = '0;
        end
        MODE_BURST: begin
          case (state)
            ST_IDLE: begin
              cnt_nxt = '0;
              // A zero-length burst request is ignored outright.
              if (start && (burst_len != '0)) begin
                state_nxt  = ST_HIGH;
                remain_nxt = burst_len;
              end
            end
            ST_HIGH: begin
              if (terminal) begin
                phase_end = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_LOW;
              end else begin
                cnt_nxt = cnt + CNT_ONE;
              end
            end
            ST_LOW: begin
              if (terminal) begin
                phase_end = 1'b1;
                cnt_nxt   = '0;
                // The last low phase closes the burst; otherwise one blink
                // is consumed on the way back up.
                if (remain <= BURST_ONE) begin
                  state_nxt  = ST_IDLE;
                  remain_nxt = '0;
                end else begin
                  state_nxt  = ST_HIGH;
                  remain_nxt = remain - BURST_ONE;
                end
              end else begin
                cnt_nxt = cnt + CNT_ONE;
              end
            end
            default: begin
              state_nxt  = ST_IDLE;
              cnt_nxt    = '0;
              remain_nxt = '0;
            end
          endcase
        end
        default: begin
          // OFF and SOLID both park the FSM with the counter held at zero.
          state_nxt  = ST_IDLE;
          cnt_nxt    = '0;
          remain_nxt = '0;
        end
      endcase
    end
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe
  always_comb begin
    blink_nxt = (state_nxt == ST_HIGH) || (!abort && (mode == MODE_SOLID));
    tick_nxt  = phase_end;
    busy_nxt  = (state_nxt != ST_IDLE) && (mode == MODE_BURST);
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_out <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      blink_out <= blink_nxt;
      tick      <= tick_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: rtl/blink_gen_multi.sv
// Multi-channel programmable blink generator for LED/display blink enables.
// Latency: one cycle from inputs to registered outputs on every channel.
// Backpressure: none; channels free-run independently with no flow control.
module blink_gen_multi
  import blink_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic                       CLOCK_60Hz,
  input  logic                       RESET,
  input  logic [NUM_CH-1:0]          enable,
  input  logic [MODE_W*NUM_CH-1:0]   mode,
  input  logic [CNT_W*NUM_CH-1:0]    half_period,
  input  logic [BURST_W*NUM_CH-1:0]  burst_len,
  input  logic [NUM_CH-1:0]          start,
  output logic [NUM_CH-1:0]          blink_out,
  output logic [NUM_CH-1:0]          tick,
  output logic [NUM_CH-1:0]          busy
);

  // One fully independent channel per lane; nothing is shared between them.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    blink_channel #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_ch (
      .clk         (CLOCK_60Hz),
      .rst         (RESET),
      .enable      (enable[i]),
      .mode        (mode[MODE_W*i +: MODE_W]),
      .half_period (half_period[CNT_W*i +: CNT_W]),
      .burst_len   (burst_len[BURST_W*i +: BURST_W]),
      .start       (start[i]),
      .blink_out   (blink_out[i]),
      .tick        (tick[i]),
      .busy        (busy[i])
    );
  end

endmodule

// File: tb/tb_blink_gen_multi.sv
// Self-checking bench for blink_gen_multi using an expected-output queue.
// Latency: expectations are for the registered outputs after each edge.
// Backpressure: n/a.
module tb_blink_gen_multi;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int BURST_W = 4;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_FREE  = 2'd1;
  localparam logic [1:0] M_BURST = 2'd2;
  localparam logic [1:0] M_SOLID = 2'd3;

  typedef struct {
    int         ch;
    int         cyc;
    logic [2:0] v;   // {blink_out, tick, busy}
  } exp_t;

  logic                      clk;
  logic                      rst;
  logic [NUM_CH-1:0]         enable;
  logic [2*NUM_CH-1:0]       mode;
  logic [CNT_W*NUM_CH-1:0]   half_period;
  logic [BURST_W*NUM_CH-1:0] burst_len;
  logic [NUM_CH-1:0]         start;
  logic [NUM_CH-1:0]         blink_out;
  logic [NUM_CH-1:0]         tick;
  logic [NUM_CH-1:0]         busy;

  int    checks = 0;
  int    errors = 0;
  string tname;
  exp_t  sb[$];

  blink_gen_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) dut (
    .CLOCK_60Hz  (clk),
    .RESET       (rst),
    .enable      (enable),
    .mode        (mode),
    .half_period (half_period),
    .burst_len   (burst_len),
    .start       (start),
    .blink_out   (blink_out),
    .tick        (tick),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int cyc, input logic b, input logic t, input logic y);
    exp_t e;
    e.ch  = ch;
    e.cyc = cyc;
    e.v   = {b, t, y};
    sb.push_back(e);
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m, input logic [CNT_W-1:0] h,
                        input logic [BURST_W-1:0] n);
    mode[2*ch +: 2]                = m;
    half_period[CNT_W*ch +: CNT_W] = h;
    burst_len[BURST_W*ch +: BURST_W] = n;
  endtask

  task automatic idle_all();
    enable      = '0;
    start       = '0;
    mode        = '0;
    half_period = '0;
    burst_len   = '0;
    step();
  endtask

  task automatic test_reset();
    tname       = "reset";
    rst         = 1'b1;
    enable      = '0;
    start       = '0;
    mode        = '0;
    half_period = '0;
    burst_len   = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({blink_out, tick, busy} !== '0) begin
        errors++;
        $display("FAIL %s held cyc%0d blink/tick/busy got %b/%b/%b want 0/0/0",
                 tname, i, blink_out, tick, busy);
      end
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({blink_out, tick, busy} !== '0) begin
      errors++;
      $display("FAIL %s released blink/tick/busy got %b/%b/%b want 0/0/0",
               tname, blink_out, tick, busy);
    end
  endtask

  task automatic test_free();
    exp_t       e;
    logic [2:0] got;
    tname = "free_h2";
    set_ch(0, M_FREE, 8'd2, 4'd0);
    step();
    enable[0] = 1'b1;
    for (int j = 0; j < 61; j++) begin
      push(0, j, ((j / 3) % 2) == 0, (j > 0) && (j % 3 == 0), 1'b0);
      step();
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {blink_out[e.ch], tick[e.ch], busy[e.ch]};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s ch%0d cyc%0d {blink,tick,busy} got %b want %b", tname, e.ch, e.cyc, got, e.v);
        end
      end
    end
    // Channel 0 is high here; reset must clear it without any clock edge.
    tname = "reset_async";
    rst   = 1'b1;
    #1;
    checks++;
    if ({blink_out[0], tick[0], busy[0]} !== 3'b000) begin
      errors++;
      $display("FAIL %s ch0 {blink,tick,busy} got %b want 000", tname,
               {blink_out[0], tick[0], busy[0]});
    end
    #2;
    rst    = 1'b0;
    enable = '0;
    mode   = '0;
    step();
  endtask

  task automatic test_burst();
    exp_t       e;
    logic [2:0] got;
    int         busy_cycles;
    tname       = "burst_n3";
    busy_cycles = 0;
    set_ch(1, M_BURST, 8'd1, 4'd3);
    enable[1] = 1'b1;
    step();
    step();
    for (int j = 0; j < 16; j++) begin
      start[1] = (j == 0) || (j == 5);
      burst_len[BURST_W*1 +: BURST_W] = (j >= 3) ? 4'd7 : 4'd3;
      if (j < 12) push(1, j, ((j / 2) % 2) == 0, (j > 0) && (j % 2 == 0), 1'b1);
      else        push(1, j, 1'b0, j == 12, 1'b0);
      step();
      if (busy[1] === 1'b1) busy_cycles++;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {blink_out[e.ch], tick[e.ch], busy[e.ch]};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s ch%0d cyc%0d {blink,tick,busy} got %b want %b", tname, e.ch, e.cyc, got, e.v);
        end
      end
    end
    start = '0;
    checks++;
    if (busy_cycles != 12) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want 12", tname, busy_cycles);
    end
  endtask

  task automatic test_h_change();
    exp_t       e;
    logic [2:0] got;
    int         k;
    tname = "h_change";
    set_ch(2, M_FREE, 8'd10, 4'd0);
    step();
    enable[2] = 1'b1;
    for (int j = 0; j < 33; j++) begin
      if (j >= 8) half_period[CNT_W*2 +: CNT_W] = 8'd3;
      if (j < 8) begin
        push(2, j, 1'b1, 1'b0, 1'b0);
      end else begin
        k = j - 8;
        push(2, j, ((k / 4) % 2) == 1, (k % 4) == 0, 1'b0);
      end
      step();
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {blink_out[e.ch], tick[e.ch], busy[e.ch]};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s ch%0d cyc%0d {blink,tick,busy} got %b want %b", tname, e.ch, e.cyc, got, e.v);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    exp_t       e;
    logic [2:0] got;
    tname = "enable_drop";
    set_ch(3, M_BURST, 8'd2, 4'd5);
    enable[3] = 1'b1;
    step();
    step();
    for (int j = 0; j < 21; j++) begin
      start[3]  = (j == 0);
      enable[3] = !((j >= 10) && (j < 13));
      if (j < 10) push(3, j, ((j / 3) % 2) == 0, (j > 0) && (j % 3 == 0), 1'b1);
      else        push(3, j, 1'b0, 1'b0, 1'b0);
      step();
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {blink_out[e.ch], tick[e.ch], busy[e.ch]};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s ch%0d cyc%0d {blink,tick,busy} got %b want %b", tname, e.ch, e.cyc, got, e.v);
        end
      end
    end
    start = '0;
  endtask

  task automatic test_concurrent();
    exp_t       e;
    logic [2:0] got;
    tname = "concurrent";
    set_ch(0, M_FREE,  8'd0, 4'd0);
    set_ch(1, M_SOLID, 8'd5, 4'd0);
    set_ch(2, M_OFF,   8'd1, 4'd2);
    set_ch(3, M_BURST, 8'd4, 4'd0);
    enable = '0;
    step();
    enable = '1;
    for (int j = 0; j < 20; j++) begin
      start[3] = (j == 2) || (j == 5);
      burst_len[BURST_W*3 +: BURST_W] = (j == 5) ? 4'd1 : 4'd0;
      push(0, j, (j % 2) == 0, j > 0, 1'b0);
      push(1, j, 1'b1, 1'b0, 1'b0);
      push(2, j, 1'b0, 1'b0, 1'b0);
      if ((j >= 5) && (j < 15)) push(3, j, j < 10, j == 10, 1'b1);
      else                      push(3, j, 1'b0, j == 15, 1'b0);
      step();
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {blink_out[e.ch], tick[e.ch], busy[e.ch]};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL %s ch%0d cyc%0d {blink,tick,busy} got %b want %b", tname, e.ch, e.cyc, got, e.v);
        end
      end
    end
    start = '0;
  endtask

  initial begin
    test_reset();
    idle_all();
    test_free();
    idle_all();
    test_burst();
    idle_all();
    test_h_change();
    idle_all();
    test_enable_drop();
    idle_all();
    test_concurrent();
    idle_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_gen_multi.md
Name: blink_gen_multi

Overview:
- Multi-channel, run-time programmable blink generator for the board UI (cursor blink, win-line flash, error flash).
- Generalises the fixed single-output toggle divider: NUM_CH independent channels, per-channel half-period input, four modes including a counted burst.
- Runs from the board slow clock and drives the LED/display blink enables directly.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 8, width of per-channel half-period and internal counter.
- BURST_W, 4, width of per-channel burst count.

Ports:
- CLOCK_60Hz  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- enable  in  NUM_CH  per-channel enable; low forces channel idle.
- mode  in  2*NUM_CH  per-channel mode, channel i at [2i+1:2i].
- half_period  in  CNT_W*NUM_CH  per-channel terminal count H, channel i at [CNT_W*i +: CNT_W].
- burst_len  in  BURST_W*NUM_CH  blinks per burst N, sampled at start.
- start  in  NUM_CH  one-cycle pulse that launches a burst (mode BURST only).
- blink_out  out  NUM_CH  registered blink level.
- tick  out  NUM_CH  one-cycle pulse at each half-period boundary.
- busy  out  NUM_CH  high while a burst is in progress.

Behaviour:
- Reset (asynchronous): all counters 0, all channels in state IDLE, blink_out=0, tick=0, busy=0.
- Mode encoding:
  - 0 OFF
  - 1 FREE (continuous square wave)
  - 2 BURST (N blinks then stop)
  - 3 SOLID (blink_out=1, counter held 0, tick=0)
- Per-channel FSM states: IDLE, HIGH, LOW.
- The counter increments every cycle in HIGH or LOW.
- Terminal condition is counter >= H (">=", so lowering H mid-phase ends the phase on the next cycle instead of wrapping through 2^CNT_W). On terminal:
  - counter returns to 0.
  - tick=1 for that cycle (registered; asserts in the same cycle the blink_out edge appears).
  - state flips.
- Each phase lasts H+1 cycles. Full period is 2(H+1). H=0 toggles every cycle.
- blink_out=1 exactly in HIGH (and in SOLID); 0 in IDLE and LOW. All outputs are registered.
- FREE mode:
  - IDLE -> HIGH on the first cycle enable=1, mode=FREE.
  - HIGH <-> LOW forever.
  - busy stays 0.
- BURST mode:
  - In IDLE with start=1 and burst_len!=0: capture N, clear counter, go to HIGH next cycle, busy=1 from that cycle.
  - Remaining count decrements at each LOW->HIGH transition.
  - The terminal of the Nth LOW phase goes to IDLE and busy drops to 0 in that same cycle.
  - A burst is exactly 2N(H+1) cycles of busy.
  - start while busy is ignored. start with burst_len=0 is ignored.
  - burst_len changes mid-burst have no effect.
- enable=0 (synchronous): next cycle IDLE, counter 0, blink_out=0, busy=0, pending burst discarded.
- Mode change: any cycle where mode differs from the registered previous mode, the channel aborts to IDLE as for enable=0, then obeys the new mode from the following cycle.
- Simultaneous events: enable=0 or mode change wins over start; start wins over nothing else.
- Channels are fully independent. There is no shared counter.
- Mid-operation RESET: immediate return to reset values; no burst resumes after release.

Decomposition:
- Package blink_pkg:
  - mode localparams MODE_OFF/FREE/BURST/SOLID.
  - state localparams ST_IDLE/HIGH/LOW.
  - state width constant.
- Sub-module blink_channel holds one channel's FSM, counter, burst counter and output registers.
  - Parameters: CNT_W, BURST_W.
  - Instantiated NUM_CH times in a generate loop that slices the packed buses.

Test Plan:
- RESET held 3 cycles, then released with enable=0 -> blink_out, tick and busy all 0 on every channel; asserting RESET mid-blink clears blink_out with no clock edge.
- ch0 FREE, H=2 -> blink_out high 3 / low 3 repeating; tick every 3 cycles; 10 periods checked.
- ch1 BURST, H=1, N=3, start pulse -> busy high exactly 12 cycles; 3 high pulses of 2 cycles each; then IDLE; a second start during busy has no effect.
- ch2 FREE, H=10; change H to 3 when counter=7 -> phase ends next cycle; subsequent phases are 4 cycles.
- ch3 BURST, N=5; drop enable after the 2nd blink -> blink_out=0 and busy=0 next cycle; re-enable with no start stays IDLE.
- All channels run concurrently with different H and modes (FREE H=0, SOLID, OFF, BURST N=1) -> each matches its own golden trace; H=0 toggles every cycle; burst_len=0 start is ignored.
